// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 4-stage IF/DOF/EX/WB pipeline: drives PC/IR enables,
// inserts EX bubbles, carries RW/DA/MW down to EX and WB, and counts stall cycles.
module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DHS,
    input  logic             B_D,
    input  logic             RW_d,
    input  logic [2:0]       DA_d,
    input  logic             MW_d,
    output logic             PC_EN,
    output logic             IR_EN,
    output logic             RW_ex,
    output logic [2:0]       DA_ex,
    output logic             MW_ex,
    output logic             RW_wb,
    output logic [2:0]       DA_wb,
    output logic             STALL,
    output logic             FLUSH,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_e            state_q, state_d;
    logic [2:0]        flush_rem_q, flush_rem_d;
    logic              rw_ex_q, rw_ex_d;
    logic [2:0]        da_ex_q, da_ex_d;
    logic              mw_ex_q, mw_ex_d;
    logic              rw_wb_q, rw_wb_d;
    logic [2:0]        da_wb_q, da_wb_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic pc_en, ir_en, stall, flush, bubble;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_rem_d = flush_rem_q;
        stall_cnt_d = stall_cnt_q;
        pc_en       = 1'b0;
        ir_en       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        bubble      = 1'b1;

        unique case (state_q)
            ST_RUN: begin
                if (!B_D) begin
                    // Branch wins over a simultaneous hazard: the stalled operand is squashed anyway.
                    pc_en       = 1'b1;
                    ir_en       = 1'b1;
                    flush       = 1'b1;
                    state_d     = ST_FLUSH;
                    flush_rem_d = FLUSH_INIT;
                end else if (!DHS) begin
                    stall = 1'b1;
                    if (stall_cnt_q != '1) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    pc_en  = 1'b1;
                    ir_en  = 1'b1;
                    bubble = 1'b0;
                end
            end
            ST_FLUSH: begin
                pc_en       = 1'b1;
                ir_en       = 1'b1;
                flush       = 1'b1;
                flush_rem_d = flush_rem_q - 3'd1;
                if (flush_rem_q <= 3'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A bubble zeroes DA as well as the enables so downstream comparators see nothing.
    always_comb begin
        rw_ex_d = bubble ? 1'b0 : RW_d;
        da_ex_d = bubble ? 3'd0 : DA_d;
        mw_ex_d = bubble ? 1'b0 : MW_d;
        rw_wb_d = rw_ex_q;
        da_wb_d = da_ex_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_rem_q <= 3'd0;
            rw_ex_q     <= 1'b0;
            da_ex_q     <= 3'd0;
            mw_ex_q     <= 1'b0;
            rw_wb_q     <= 1'b0;
            da_wb_q     <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_rem_q <= flush_rem_d;
            rw_ex_q     <= rw_ex_d;
            da_ex_q     <= da_ex_d;
            mw_ex_q     <= mw_ex_d;
            rw_wb_q     <= rw_wb_d;
            da_wb_q     <= da_wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Enables are forced low for the whole reset assertion, not just until the next edge.
    assign PC_EN     = pc_en & ~reset;
    assign IR_EN     = ir_en & ~reset;
    assign STALL     = stall & ~reset;
    assign FLUSH     = flush & ~reset;
    assign RW_ex     = rw_ex_q;
    assign DA_ex     = da_ex_q;
    assign MW_ex     = mw_ex_q;
    assign RW_wb     = rw_wb_q;
    assign DA_wb     = da_wb_q;
    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: a vector table for the main flow,
// hand sequences for counter saturation and asynchronous reset.
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       DHS = 1'b1;
    logic       B_D = 1'b1;
    logic       RW_d = 1'b0;
    logic [2:0] DA_d = 3'd0;
    logic       MW_d = 1'b0;

    logic        PC_EN, IR_EN, RW_ex, MW_ex, RW_wb, STALL, FLUSH;
    logic [2:0]  DA_ex, DA_wb;
    logic [15:0] STALL_CNT;

    logic        s_pc_en, s_ir_en, s_rw_ex, s_mw_ex, s_rw_wb, s_stall, s_flush;
    logic [2:0]  s_da_ex, s_da_wb;
    logic [1:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .DHS(DHS), .B_D(B_D),
        .RW_d(RW_d), .DA_d(DA_d), .MW_d(MW_d),
        .PC_EN(PC_EN), .IR_EN(IR_EN),
        .RW_ex(RW_ex), .DA_ex(DA_ex), .MW_ex(MW_ex),
        .RW_wb(RW_wb), .DA_wb(DA_wb),
        .STALL(STALL), .FLUSH(FLUSH), .STALL_CNT(STALL_CNT)
    );

    pipeline_stall_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .DHS(DHS), .B_D(B_D),
        .RW_d(RW_d), .DA_d(DA_d), .MW_d(MW_d),
        .PC_EN(s_pc_en), .IR_EN(s_ir_en),
        .RW_ex(s_rw_ex), .DA_ex(s_da_ex), .MW_ex(s_mw_ex),
        .RW_wb(s_rw_wb), .DA_wb(s_da_wb),
        .STALL(s_stall), .FLUSH(s_flush), .STALL_CNT(s_stall_cnt)
    );

    typedef struct {
        logic       dhs, b_d, rw_d;
        logic [2:0] da_d;
        logic       mw_d;
        logic       pc_en, ir_en, stall, flush;
        logic       rw_ex;
        logic [2:0] da_ex;
        logic       mw_ex, rw_wb;
        logic [2:0] da_wb;
        int         cnt;
    } vec_t;

    typedef struct {
        logic       rw_ex;
        logic [2:0] da_ex;
        logic       mw_ex, rw_wb;
        logic [2:0] da_wb;
        int         cnt;
    } exp_t;

    localparam int NV = 12;
    vec_t vecs[NV];
    exp_t sb_q[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic dhs, input logic b_d, input logic rw,
                         input logic [2:0] da, input logic mw);
        DHS  = dhs;
        B_D  = b_d;
        RW_d = rw;
        DA_d = da;
        MW_d = mw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        #1;
        check("rst_pc_en", int'(PC_EN), 0);
        check("rst_ir_en", int'(IR_EN), 0);
        check("rst_stall", int'(STALL), 0);
        check("rst_flush", int'(FLUSH), 0);
        check("rst_rw_ex", int'(RW_ex), 0);
        check("rst_da_wb", int'(DA_wb), 0);
        check("rst_cnt",   int'(STALL_CNT), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_rw_ex"}, int'(RW_ex), int'(e.rw_ex));
        check({tag, "_da_ex"}, int'(DA_ex), int'(e.da_ex));
        check({tag, "_mw_ex"}, int'(MW_ex), int'(e.mw_ex));
        check({tag, "_rw_wb"}, int'(RW_wb), int'(e.rw_wb));
        check({tag, "_da_wb"}, int'(DA_wb), int'(e.da_wb));
        check({tag, "_cnt"},   int'(STALL_CNT), e.cnt);
    endtask

    initial begin
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        // Main DUT uses FLUSH_CYCLES=2. Columns:
        // dhs b_d rw da mw | pc ir stall flush | rw_ex da_ex mw_ex rw_wb da_wb cnt (after edge)
        vecs[0]  = '{1, 1, 1, 5, 0,  1, 1, 0, 0,  1, 5, 0,  0, 0, 0};
        vecs[1]  = '{1, 1, 1, 5, 0,  1, 1, 0, 0,  1, 5, 0,  1, 5, 0};
        vecs[2]  = '{1, 1, 0, 6, 1,  1, 1, 0, 0,  0, 6, 1,  1, 5, 0};
        vecs[3]  = '{0, 1, 1, 3, 0,  0, 0, 1, 0,  0, 0, 0,  0, 6, 1};
        vecs[4]  = '{0, 1, 1, 3, 0,  0, 0, 1, 0,  0, 0, 0,  0, 0, 2};
        vecs[5]  = '{1, 1, 1, 3, 0,  1, 1, 0, 0,  1, 3, 0,  0, 0, 2};
        vecs[6]  = '{0, 0, 1, 7, 1,  1, 1, 0, 1,  0, 0, 0,  1, 3, 2};
        vecs[7]  = '{0, 1, 1, 7, 1,  1, 1, 0, 1,  0, 0, 0,  0, 0, 2};
        vecs[8]  = '{0, 0, 1, 7, 1,  1, 1, 0, 1,  0, 0, 0,  0, 0, 2};
        vecs[9]  = '{0, 1, 1, 7, 1,  0, 0, 1, 0,  0, 0, 0,  0, 0, 3};
        vecs[10] = '{1, 1, 1, 2, 1,  1, 1, 0, 0,  1, 2, 1,  0, 0, 3};
        vecs[11] = '{1, 1, 0, 4, 0,  1, 1, 0, 0,  0, 4, 0,  1, 2, 3};

        do_reset();

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            drive(vecs[i].dhs, vecs[i].b_d, vecs[i].rw_d, vecs[i].da_d, vecs[i].mw_d);
            #1;
            check({tag, "_pc_en"}, int'(PC_EN), int'(vecs[i].pc_en));
            check({tag, "_ir_en"}, int'(IR_EN), int'(vecs[i].ir_en));
            check({tag, "_stall"}, int'(STALL), int'(vecs[i].stall));
            check({tag, "_flush"}, int'(FLUSH), int'(vecs[i].flush));
            e.rw_ex = vecs[i].rw_ex;
            e.da_ex = vecs[i].da_ex;
            e.mw_ex = vecs[i].mw_ex;
            e.rw_wb = vecs[i].rw_wb;
            e.da_wb = vecs[i].da_wb;
            e.cnt   = vecs[i].cnt;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            pop_and_compare(tag);
        end

        // Counter saturation: the CNT_W=2 instance must stick at 3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
            #1;
            check($sformatf("sat%0d_stall", i), int'(s_stall), 1);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d_cnt2", i), int'(s_stall_cnt), sat_exp[i]);
            check($sformatf("sat%0d_cnt16", i), int'(STALL_CNT), i + 1);
        end

        // Asynchronous reset in the last FLUSH cycle (flush_rem=1).
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
        @(negedge clk);
        #1;
        check("mf_flush_before", int'(FLUSH), 1);
        #1;
        reset = 1'b1;
        #1;
        check("mf_flush_in_rst", int'(FLUSH), 0);
        check("mf_pc_en_in_rst", int'(PC_EN), 0);
        check("mf_ir_en_in_rst", int'(IR_EN), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mf_pc_en_after", int'(PC_EN), 1);
        check("mf_flush_after", int'(FLUSH), 0);

        // Asynchronous reset in the middle of a stall with WB and counter populated.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
        @(negedge clk);
        #1;
        check("ms_stall_before", int'(STALL), 1);
        check("ms_rw_wb_before", int'(RW_wb), 1);
        check("ms_da_wb_before", int'(DA_wb), 5);
        check("ms_cnt_before",   int'(STALL_CNT), 1);
        #1;
        reset = 1'b1;
        #1;
        check("ms_stall_in_rst", int'(STALL), 0);
        check("ms_rw_wb_in_rst", int'(RW_wb), 0);
        check("ms_da_wb_in_rst", int'(DA_wb), 0);
        check("ms_cnt_in_rst",   int'(STALL_CNT), 0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;
        #1;
        check("ms_pc_en_after", int'(PC_EN), 1);
        check("ms_flush_after", int'(FLUSH), 0);
        check("ms_stall_after", int'(STALL), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
